// File: rtl/rv_lsu.sv
// rtl/rv_lsu.sv - load/store unit between the core memory stage and the data memory port
//
// Purpose:
//   Accepts one byte/half/word load or store at a time from the core and runs it
//   against a word-addressed memory port (one-cycle valid pulse out, one-cycle
//   ready pulse back). Loads return sign- or zero-extended data. Sub-word stores
//   are done as read-modify-write because the memory only takes full words.
//
// Optional feature (macro RV_LSU_MISALIGN_TRAP_EN):
//   defined   - misaligned half/word accesses complete immediately with
//               resp_err_o=1, resp_rdata_o=0 and no memory access.
//   undefined - resp_err_o is always 0; misaligned addresses are aligned down.
//
// Ports:
//   clk_i, arstn_i        clock, asynchronous active-low reset
//   req_valid_i/ready_o   core request handshake (ready only in IDLE)
//   req_we_i              1 = store, 0 = load
//   req_size_i            00 byte, 01 half, 1x word
//   req_unsigned_i        loads: 1 = zero-extend, 0 = sign-extend
//   req_addr_i            byte address
//   req_wdata_i           right-aligned store data
//   resp_valid_o          one-cycle completion pulse
//   resp_rdata_o          extended load data (0 for stores), held until next completion
//   resp_err_o            misaligned-access error, qualified by resp_valid_o
//   mem_valid_o           one-cycle request pulse to memory
//   mem_addr_o            word address (byte address >> 2)
//   mem_wdata_o           full write word
//   mem_write_o           1 = write
//   mem_rdata_i           read word, valid with mem_ready_i
//   mem_ready_i           one-cycle completion pulse from memory

module rv_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic            mem_valid_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic            mem_write_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RMW_ISSUE,
    S_RMW_WAIT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic            r_we;
  logic            r_uns;
  logic [1:0]      r_size;
  logic [1:0]      r_off;
  logic [15:0]     r_wdata;
  logic            r_mem_valid;
  logic            r_mem_write;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_err;

  logic            w_trap;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_merged;

`ifdef RV_LSU_MISALIGN_TRAP_EN
  assign w_trap = (req_size_i == 2'b01 && req_addr_i[0]) ||
                  (req_size_i[1] && req_addr_i[1:0] != 2'b00);
`else
  assign w_trap = 1'b0;
`endif

  assign req_ready_o  = (r_state == S_IDLE);
  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = r_resp_rdata;
  assign resp_err_o   = r_resp_err;
  assign mem_valid_o  = r_mem_valid;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;
  assign mem_write_o  = r_mem_write;

  // Lane shift: halves only look at addr[1] and words at no offset bits, which is
  // what aligns misaligned accesses down when the trap is not built in.
  always_comb begin
    w_shamt = 5'd0;
    if (r_size == 2'b00) begin
      w_shamt = {r_off, 3'b000};
    end else if (r_size == 2'b01) begin
      w_shamt = {r_off[1], 4'b0000};
    end
  end

  assign w_shifted = mem_rdata_i >> w_shamt;

  always_comb begin
    w_load_data = w_shifted;
    if (r_size == 2'b00) begin
      w_load_data = {{(XLEN-8){~r_uns & w_shifted[7]}}, w_shifted[7:0]};
    end else if (r_size == 2'b01) begin
      w_load_data = {{(XLEN-16){~r_uns & w_shifted[15]}}, w_shifted[15:0]};
    end
  end

  // Read-modify-write merge: only the addressed lane is replaced.
  always_comb begin
    w_merged = mem_rdata_i;
    if (r_size == 2'b00) begin
      w_merged[w_shamt +: 8] = r_wdata[7:0];
    end else begin
      w_merged[w_shamt +: 16] = r_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      r_wdata      <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_we    <= req_we_i;
            r_uns   <= req_unsigned_i;
            r_size  <= req_size_i;
            r_off   <= req_addr_i[1:0];
            r_wdata <= req_wdata_i[15:0];
            if (w_trap) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
              r_state      <= S_DONE;
            end else begin
              r_mem_valid <= 1'b1;
              // Sub-word stores start with a read of the target word.
              r_mem_write <= req_we_i & req_size_i[1];
              r_mem_addr  <= {2'b00, req_addr_i[XLEN-1:2]};
              r_mem_wdata <= req_wdata_i;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_mem_valid <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_ready_i) begin
            if (!r_we) begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= w_load_data;
              r_resp_err   <= 1'b0;
              r_state      <= S_DONE;
            end else if (r_size[1]) begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_resp_err   <= 1'b0;
              r_state      <= S_DONE;
            end else begin
              r_mem_valid <= 1'b1;
              r_mem_write <= 1'b1;
              r_mem_wdata <= w_merged;
              r_state     <= S_RMW_ISSUE;
            end
          end
        end
        S_RMW_ISSUE: begin
          r_mem_valid <= 1'b0;
          r_state     <= S_RMW_WAIT;
        end
        S_RMW_WAIT: begin
          if (mem_ready_i) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          r_resp_valid <= 1'b0;
          r_mem_write  <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// tb/tb_rv_lsu.sv - scoreboard bench for rv_lsu with a behavioural word memory

module tb_rv_lsu;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_write_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;

  rv_lsu #(.XLEN(32)) dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_valid_o    (mem_valid_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_write_o    (mem_write_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_ready_i    (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } op_t;

  resp_t       exp_q[$];
  op_t         op_q[$];
  logic [31:0] mem [0:63];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          mem_lat = 1;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: sees the request pulse on a falling edge, answers mem_lat cycles later.
  initial begin : memory_model
    logic        busy;
    int          cnt;
    op_t         cur;
    op_t         e;
    busy        = 1'b0;
    cnt         = 0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk_i);
      mem_ready_i = 1'b0;
      mem_rdata_i = 32'hDEAD_BEEF;
      if (!arstn_i) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            mem_ready_i = 1'b1;
            mem_rdata_i = mem[cur.addr[5:0]];
            if (cur.wr) mem[cur.addr[5:0]] = cur.wdata;
            busy = 1'b0;
          end
        end
        if (mem_valid_o === 1'b1) begin
          cur.addr  = mem_addr_o;
          cur.wr    = mem_write_o;
          cur.wdata = mem_wdata_o;
          chk("mem_pulse_while_busy", {31'b0, busy}, 32'd0);
          if (op_q.size() == 0) begin
            chk("mem_unexpected_pulse", 32'd1, 32'd0);
          end else begin
            e = op_q.pop_front();
            chk("mem_addr", cur.addr, e.addr);
            chk("mem_write", {31'b0, cur.wr}, {31'b0, e.wr});
            if (e.wr) chk("mem_wdata", cur.wdata, e.wdata);
          end
          busy = 1'b1;
          cnt  = mem_lat;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT completes.
  initial begin : resp_monitor
    resp_t e;
    forever begin
      @(negedge clk_i);
      if (resp_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata_o, e.rdata);
          chk("resp_err", {31'b0, resp_err_o}, {31'b0, e.err});
          chk("resp_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic push_op(input logic [31:0] a, input logic w, input logic [31:0] d);
    op_q.push_back('{addr: a, wr: w, wdata: d});
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    int t;
    t = 0;
    while (req_ready_o !== 1'b1 && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    if (req_ready_o !== 1'b1) chk("req_ready_timeout", {31'b0, req_ready_o}, 32'd1);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = a;
    req_wdata_i    = wd;
  endtask

  // Issue a request and record its expected response and completion cycle.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat);
    drive(we, sz, uns, a, wd);
    exp_q.push_back('{rdata: er, err: ee, due: cyc + lat});
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || op_q.size() != 0 || req_ready_o !== 1'b1) && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 300) chk("drain_timeout", exp_q.size() + op_q.size(), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[16]        = 32'h8765_4321;
    arstn_i        = 1'b0;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_size_i     = 2'b00;
    req_unsigned_i = 1'b0;
    req_addr_i     = 32'h0;
    req_wdata_i    = 32'h0;

    repeat (2) @(negedge clk_i);
    chk("rst_req_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    chk("rst_resp_rdata", resp_rdata_o, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err_o}, 32'd0);
    chk("rst_mem_valid", {31'b0, mem_valid_o}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    arstn_i = 1'b1;
    @(negedge clk_i);

    // Loads over 0x8765_4321
    mem_lat = 1;
    push_op(32'h10, 1'b0, 32'h0); issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h8765_4321, 1'b0, 3);
    mem_lat = 2;
    push_op(32'h10, 1'b0, 32'h0); issue(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 32'hFFFF_FF87, 1'b0, 4);
    push_op(32'h10, 1'b0, 32'h0); issue(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 32'h0000_0087, 1'b0, 4);
    push_op(32'h10, 1'b0, 32'h0); issue(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'hFFFF_8765, 1'b0, 4);
    push_op(32'h10, 1'b0, 32'h0); issue(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 32'h0000_4321, 1'b0, 4);
    push_op(32'h10, 1'b0, 32'h0); issue(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 32'h0000_0043, 1'b0, 4);
    push_op(32'h10, 1'b0, 32'h0); issue(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 32'h0000_4321, 1'b0, 4);

    // Byte store as read-modify-write, then read back
    wait_idle();
    mem[16] = 32'h1122_3344;
    mem_lat = 1;
    push_op(32'h10, 1'b0, 32'h0); push_op(32'h10, 1'b1, 32'h1122_AA44);
    issue(1'b1, 2'b00, 1'b0, 32'h41, 32'hFFFF_FFAA, 32'h0, 1'b0, 5);
    push_op(32'h10, 1'b0, 32'h0); issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1122_AA44, 1'b0, 3);

    // Half store with slow memory, then read back
    wait_idle();
    mem[16] = 32'h1122_3344;
    mem_lat = 3;
    push_op(32'h10, 1'b0, 32'h0); push_op(32'h10, 1'b1, 32'hBEEF_3344);
    issue(1'b1, 2'b01, 1'b0, 32'h42, 32'h1234_BEEF, 32'h0, 1'b0, 9);
    push_op(32'h10, 1'b0, 32'h0); issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hBEEF_3344, 1'b0, 5);

    // Top byte / low half merges, word store, size 11 as word
    mem_lat = 1;
    push_op(32'h10, 1'b0, 32'h0); push_op(32'h10, 1'b1, 32'h55EF_3344);
    issue(1'b1, 2'b00, 1'b0, 32'h43, 32'h0000_0055, 32'h0, 1'b0, 5);
    push_op(32'h10, 1'b0, 32'h0); push_op(32'h10, 1'b1, 32'h55EF_0102);
    issue(1'b1, 2'b01, 1'b0, 32'h40, 32'hFFFF_0102, 32'h0, 1'b0, 5);
    push_op(32'h11, 1'b1, 32'hCAFE_F00D);
    issue(1'b1, 2'b10, 1'b0, 32'h44, 32'hCAFE_F00D, 32'h0, 1'b0, 3);
    push_op(32'h11, 1'b0, 32'h0); issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'hCAFE_F00D, 1'b0, 3);
    push_op(32'h11, 1'b0, 32'h0); issue(1'b0, 2'b11, 1'b1, 32'h44, 32'h0, 32'hCAFE_F00D, 1'b0, 3);

    // Misaligned accesses
`ifdef RV_LSU_MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 2'b01, 1'b0, 32'h43, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 2'b10, 1'b0, 32'h45, 32'h0BAD_F00D, 32'h0, 1'b1, 1);
    push_op(32'h11, 1'b0, 32'h0); issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'hCAFE_F00D, 1'b0, 3);
    wait_idle();
    chk("rdata_hold", resp_rdata_o, 32'hCAFE_F00D);
`else
    push_op(32'h10, 1'b0, 32'h0); issue(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 32'h55EF_0102, 1'b0, 3);
    push_op(32'h10, 1'b0, 32'h0); issue(1'b0, 2'b01, 1'b0, 32'h43, 32'h0, 32'h0000_55EF, 1'b0, 3);
    push_op(32'h11, 1'b1, 32'h0BAD_F00D);
    issue(1'b1, 2'b10, 1'b0, 32'h45, 32'h0BAD_F00D, 32'h0, 1'b0, 3);
    push_op(32'h11, 1'b0, 32'h0); issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h0BAD_F00D, 1'b0, 3);
    wait_idle();
    chk("rdata_hold", resp_rdata_o, 32'h0BAD_F00D);
`endif

    // Reset while waiting on memory: no response, clean restart
    mem_lat = 6;
    push_op(32'h10, 1'b0, 32'h0);
    drive(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b0;
    #1;
    chk("abort_mem_valid", {31'b0, mem_valid_o}, 32'd0);
    chk("abort_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    chk("abort_req_ready", {31'b0, req_ready_o}, 32'd1);
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;
    repeat (10) @(negedge clk_i);
    mem_lat = 1;
    push_op(32'h10, 1'b0, 32'h0); issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h55EF_0102, 1'b0, 3);

    wait_idle();
    repeat (3) @(negedge clk_i);
    chk("final_resp_queue", exp_q.size(), 32'd0);
    chk("final_op_queue", op_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
